// File: rtl/ram_bus_controller.sv
// rtl/ram_bus_controller.sv - CPU-to-block-RAM strobe sequencer on a shared tristate data bus
module ram_bus_controller #(
  parameter int          RAM_BUS_SIZE = 11,
  parameter int          RAM_WORDS    = 2048,
  parameter logic [15:0] ERR_DATA     = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_valid,
  output logic                    cpu_ready,
  input  logic                    cpu_we,
  input  logic [15:0]             cpu_addr,
  input  logic [15:0]             cpu_wdata,
  output logic                    cpu_resp,
  output logic [15:0]             cpu_rdata,
  output logic                    cpu_err,
  inout  wire  [15:0]             data_bus,
  output logic [RAM_BUS_SIZE-1:0] address_bus,
  output logic                    enable,
  output logic                    write,
  output logic                    read
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  // Compare in 17 bits so a window of exactly 64K words still decodes.
  localparam logic [16:0] WINDOW_END = 17'(RAM_WORDS);

  state_t                  state;
  state_t                  state_next;
  logic [RAM_BUS_SIZE-1:0] addr_q;
  logic [15:0]             wdata_q;
  logic                    accept;
  logic                    in_window;
  logic                    drive_bus;

  assign accept    = cpu_valid & cpu_ready;
  assign in_window = ({1'b0, cpu_addr} < WINDOW_END);

  // The controller drives the bus only while in WR; otherwise it is released.
  assign data_bus    = drive_bus ? wdata_q : 16'hzzzz;
  assign address_bus = addr_q;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: decode on accept, then walk the fixed strobe sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_window) begin
            state_next = ERR;
          end else if (cpu_we) begin
            state_next = WR;
          end else begin
            state_next = RD_ADDR;
          end
        end
      end
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so RAM strobes never
  // follow CPU inputs combinationally. DONE doubles as bus turnaround.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_resp  = 1'b0;
    cpu_err   = 1'b0;
    enable    = 1'b0;
    write     = 1'b0;
    read      = 1'b0;
    drive_bus = 1'b0;
    case (state)
      IDLE: begin
        cpu_ready = rst_n;
      end
      RD_ADDR: begin
        enable = 1'b1;
      end
      RD_DATA: begin
        read = 1'b1;
      end
      WR: begin
        enable    = 1'b1;
        write     = 1'b1;
        drive_bus = 1'b1;
      end
      DONE: begin
        cpu_resp = 1'b1;
      end
      ERR: begin
        cpu_resp = 1'b1;
        cpu_err  = 1'b1;
      end
      default: begin
        cpu_ready = 1'b0;
      end
    endcase
  end

  // Request capture and read-data return; writes never touch cpu_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cpu_addr[RAM_BUS_SIZE-1:0];
        wdata_q <= cpu_wdata;
        if (!in_window && !cpu_we) begin
          cpu_rdata <= ERR_DATA;
        end
      end
      if (state == RD_DATA) begin
        cpu_rdata <= data_bus;
      end
    end
  end

endmodule

// File: tb/tb_ram_bus_controller.sv
// tb/tb_ram_bus_controller.sv - directed self-checking bench for ram_bus_controller
module tb_ram_bus_controller;

  localparam int RAM_BUS_SIZE = 11;
  localparam int RAM_WORDS    = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  wire         cpu_ready;
  wire         cpu_resp;
  wire         cpu_err;
  wire  [15:0] cpu_rdata;
  wire  [15:0] data_bus;
  wire  [RAM_BUS_SIZE-1:0] address_bus;
  wire         enable;
  wire         write;
  wire         read;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_read_cyc = -100;
  logic [15:0] exp_rdata;

  always #5 clk = ~clk;

  ram_bus_controller #(
    .RAM_BUS_SIZE(RAM_BUS_SIZE),
    .RAM_WORDS(RAM_WORDS),
    .ERR_DATA(16'hFFFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_valid(cpu_valid),
    .cpu_ready(cpu_ready),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_resp(cpu_resp),
    .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err),
    .data_bus(data_bus),
    .address_bus(address_bus),
    .enable(enable),
    .write(write),
    .read(read)
  );

  // Block RAM model: writes on enable&write, latches output on enable alone,
  // drives the bus while read is high.
  logic [15:0] mem [0:RAM_WORDS-1];
  logic [15:0] ram_q;

  always @(posedge clk) begin
    if (enable === 1'b1 && write === 1'b1) begin
      mem[address_bus] <= data_bus;
    end else if (enable === 1'b1) begin
      ram_q <= mem[address_bus];
    end
  end

  assign data_bus = (read === 1'b1) ? ram_q : 16'hzzzz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Sample mid-cycle and enforce the bus-sharing rules on every observed cycle.
  task automatic probe();
    @(negedge clk);
    if (read === 1'b1) begin
      chk("no_strobe_while_read", {14'd0, enable, write}, 16'h0000);
      last_read_cyc = cyc;
    end
    if (enable === 1'b1 && write === 1'b1) begin
      chk("turnaround_gap", {15'd0, (cyc - last_read_cyc) >= 3}, 16'h0001);
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input bit err);
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    probe();
    chk("wr_ready", {15'd0, cpu_ready}, 16'h0001);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    probe();
    if (err) begin
      chk("wr_err_resp", {13'd0, cpu_resp, cpu_err, enable}, 16'h0006);
      chk("wr_err_rdata_held", cpu_rdata, exp_rdata);
    end else begin
      chk("wr_strobes", {12'd0, enable, write, read, cpu_resp}, 16'h000C);
      chk("wr_bus", data_bus, data);
      chk("wr_addr", {5'd0, address_bus}, {5'd0, addr[RAM_BUS_SIZE-1:0]});
      probe();
      chk("wr_done", {12'd0, enable, write, cpu_resp, cpu_err}, 16'h0002);
      chk("wr_rdata_held", cpu_rdata, exp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [15:0] expv, input bit err);
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = addr;
    cpu_wdata = 16'h0000;
    probe();
    chk("rd_ready", {15'd0, cpu_ready}, 16'h0001);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    probe();
    if (err) begin
      chk("rd_err_resp", {12'd0, cpu_resp, cpu_err, enable, read}, 16'h000C);
      chk("rd_err_rdata", cpu_rdata, 16'hFFFF);
      exp_rdata = 16'hFFFF;
    end else begin
      chk("rd_addr_phase", {12'd0, enable, write, read, cpu_resp}, 16'h0008);
      chk("rd_addr", {5'd0, address_bus}, {5'd0, addr[RAM_BUS_SIZE-1:0]});
      probe();
      chk("rd_data_phase", {12'd0, enable, write, read, cpu_resp}, 16'h0002);
      probe();
      chk("rd_done", {12'd0, read, enable, cpu_resp, cpu_err}, 16'h0002);
      chk("rd_rdata", cpu_rdata, expv);
      exp_rdata = expv;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0005;
    cpu_wdata = 16'h1111;
    exp_rdata = 16'h0000;

    // Reset held two cycles with a pending request
    @(posedge clk);
    probe();
    chk("rst_ready", {15'd0, cpu_ready}, 16'h0000);
    chk("rst_strobes", {12'd0, enable, write, read, cpu_resp}, 16'h0000);
    probe();
    chk("rst_ready2", {15'd0, cpu_ready}, 16'h0000);
    chk("rst_err", {15'd0, cpu_err}, 16'h0000);
    chk("rst_rdata", cpu_rdata, 16'h0000);
    chk("rst_addr", {5'd0, address_bus}, 16'h0000);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    cpu_valid = 1'b0;
    probe();
    chk("post_rst_ready", {15'd0, cpu_ready}, 16'h0001);
    chk("post_rst_no_strobe", {13'd0, enable, write, read}, 16'h0000);
    @(posedge clk); #1;

    // Write then read back
    do_write(16'h0005, 16'hBEEF, 1'b0);
    do_read(16'h0005, 16'hBEEF, 1'b0);

    // Out-of-window read
    do_read(16'h0800, 16'hFFFF, 1'b1);

    // Window boundaries, no aliasing
    do_write(16'h0000, 16'hA5A5, 1'b0);
    do_write(16'h07FF, 16'h5A5A, 1'b0);
    do_read(16'h0000, 16'hA5A5, 1'b0);
    do_read(16'h07FF, 16'h5A5A, 1'b0);

    // Out-of-window write must not alias onto 0x07FF
    do_write(16'hFFFF, 16'h1357, 1'b1);
    do_read(16'h07FF, 16'h5A5A, 1'b0);

    // Back-to-back read then write
    do_read(16'h07FF, 16'h5A5A, 1'b0);
    do_write(16'h0000, 16'h1234, 1'b0);
    do_read(16'h0000, 16'h1234, 1'b0);

    // Reset during WR
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0010;
    cpu_wdata = 16'h7777;
    probe();
    chk("mid_wr_ready", {15'd0, cpu_ready}, 16'h0001);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    probe();
    chk("mid_wr_strobe", {13'd0, enable, write, read}, 16'h0006);
    rst_n = 1'b0;
    @(posedge clk); #1;
    probe();
    chk("mid_wr_rst_strobes", {12'd0, enable, write, read, cpu_resp}, 16'h0000);
    chk("mid_wr_rst_ready", {15'd0, cpu_ready}, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    probe();
    chk("mid_wr_idle", {14'd0, cpu_ready, cpu_resp}, 16'h0002);
    chk("mid_wr_rdata_cleared", cpu_rdata, 16'h0000);
    exp_rdata = 16'h0000;
    @(posedge clk); #1;
    do_read(16'h0010, 16'h7777, 1'b0);

    // Reset during RD_DATA
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0005;
    probe();
    chk("mid_rd_ready", {15'd0, cpu_ready}, 16'h0001);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    probe();
    probe();
    chk("mid_rd_read_high", {15'd0, read}, 16'h0001);
    rst_n = 1'b0;
    @(posedge clk); #1;
    probe();
    chk("mid_rd_rst_strobes", {12'd0, enable, write, read, cpu_resp}, 16'h0000);
    chk("mid_rd_rst_rdata", cpu_rdata, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    probe();
    chk("mid_rd_idle", {14'd0, cpu_ready, cpu_resp}, 16'h0002);
    exp_rdata = 16'h0000;
    @(posedge clk); #1;
    do_read(16'h0005, 16'hBEEF, 1'b0);
    do_read(16'h0000, 16'h1234, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bus_controller.md
Name: ram_bus_controller

Overview:
- Sits between the CPU core's memory port and the block RAM: turns single-word CPU read/write requests into the RAM strobe sequence (enable/write/read) on the shared 16-bit tristate data bus.
- Owns address decode for the RAM window and bus turnaround, so the controller and the RAM never drive data_bus in the same cycle.
- Returns read data or a decode error to the CPU over a valid/ready request and one-cycle response pulse.

Parameters:
- RAM_BUS_SIZE, 11, width of the RAM address bus.
- RAM_WORDS, 2048, RAM window size in words; CPU addresses 0..RAM_WORDS-1 hit RAM; must be <= 2**RAM_BUS_SIZE.
- ERR_DATA, 16'hFFFF, value returned on cpu_rdata for an out-of-window read.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous reset, active low.
- cpu_valid  in  1  CPU request valid; held with addr/data until accepted.
- cpu_ready  out  1  controller can accept a request; accept = cpu_valid & cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  word address.
- cpu_wdata  in  16  write data.
- cpu_resp  out  1  one-cycle pulse: transfer complete.
- cpu_rdata  out  16  read data; valid when cpu_resp = 1, then held.
- cpu_err  out  1  with cpu_resp: address out of window.
- data_bus  inout  16  shared RAM data bus.
- address_bus  out  RAM_BUS_SIZE  RAM word address.
- enable  out  1  RAM access strobe.
- write  out  1  RAM write select.
- read  out  1  RAM output-drive enable.

Behaviour:
- Reset (rst_n = 0 at posedge): state IDLE; cpu_resp = 0, cpu_err = 0, cpu_rdata = 0, address_bus = 0, enable/write/read = 0; data_bus released (Z). Reset applies from any state, including mid-access: no partial RAM write is issued after the reset edge.
- States: IDLE, RD_ADDR, RD_DATA, WR, DONE, ERR.
- cpu_ready = 1 only in IDLE. On accept, cpu_addr, cpu_we and cpu_wdata are registered.
- Decode: if cpu_addr >= RAM_WORDS, go to ERR. Otherwise go to RD_ADDR if cpu_we = 0, or WR if cpu_we = 1.
- RAM strobes are decoded from the state register only (no combinational path from CPU inputs). address_bus = low RAM_BUS_SIZE bits of the registered address.
- RD_ADDR: enable = 1, write = 0, read = 0. RAM latches its output at this edge. Next state RD_DATA.
- RD_DATA: read = 1, enable = 0. RAM drives data_bus; the controller captures data_bus into cpu_rdata at the closing edge. Next state DONE.
- WR: enable = 1, write = 1, read = 0. The controller drives data_bus with the registered wdata for this cycle only. Next state DONE.
- DONE: all strobes 0, bus Z, cpu_resp = 1, cpu_err = 0. Next state IDLE. DONE is also the mandatory turnaround cycle after read = 1.
- ERR: no RAM strobe. cpu_resp = 1, cpu_err = 1, cpu_rdata = ERR_DATA for reads; cpu_rdata unchanged for writes. Next state IDLE.
- Latency from the accept edge to the cpu_resp cycle:
  - read: 3 cycles;
  - write: 2 cycles;
  - error: 1 cycle.
- Minimum request spacing: read 4 cycles, write 3 cycles.
- Bus safety invariant: the controller drives data_bus only in WR; read = 1 only in RD_DATA; these states are never adjacent. Back-to-back read then write has at least 2 cycles of Z between read falling and the controller driving.
- cpu_rdata holds its last value between responses; writes never modify it.
- cpu_valid dropping while not ready is ignored; in-flight transfers always complete.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with cpu_valid = 1 → cpu_ready = 0 during reset, all strobes 0, data_bus Z, cpu_rdata = 0; cpu_ready = 1 the first cycle after release.
- Write then read: write addr 0x0005, data 0xBEEF → enable & write high for exactly 1 cycle, bus = 0xBEEF, cpu_resp 2 cycles after accept. Then read 0x0005 → cpu_rdata = 0xBEEF, cpu_resp 3 cycles after accept, cpu_err = 0.
- Out of window: read 0x0800 → no enable/read strobe, cpu_resp + cpu_err 1 cycle after accept, cpu_rdata = 0xFFFF. Write 0xFFFF → cpu_err = 1, RAM unchanged (check via readback of 0x07FF).
- Back-to-back: read 0x07FF immediately followed by write 0x0000 = 0x1234 → bus monitor shows no cycle where read = 1 and the controller drives; no X on data_bus.
- Reset mid-operation: assert rst_n = 0 in the WR cycle and separately in RD_DATA → strobes 0 the next cycle, no cpu_resp, IDLE afterwards; a following read returns consistent data.
- Boundary: read 0x0000 and 0x07FF after writing 0xA5A5 / 0x5A5A → correct values, no aliasing.
